// File: rtl/os_array_seq_ctrl.sv
// Start/done sequencer for the output-stationary array: feed, flush, drain, gap per tile.
// Optional feed-stall counter is enabled by defining OS_SEQ_STALL_CNT_EN.
module os_array_seq_ctrl #(
  parameter int COL    = 8,
  parameter int CNT_W  = 8,
  parameter int DLY_W  = 4,
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_k_i,
  input  logic [CNT_W-1:0] num_tiles_i,
  input  logic [DLY_W-1:0] dly_i,
  input  logic             l0_rd_ready_i,
  input  logic             ififo_rd_ready_i,
  output logic [1:0]       inst_o,
  output logic             l0_rd_en_o,
  output logic             ififo_rd_en_o,
  output logic [COL-1:0]   shift_psum_o,
  output logic [CNT_W-1:0] tile_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      stall_cnt_o
);

  localparam int DW = (COL > 1) ? $clog2(COL) : 1;

  typedef enum logic [2:0] {
    IDLE, FEED, FLUSH, DRAIN, GAP
  } state_t;

  state_t state, nxt;

  logic [CNT_W-1:0] num_k, num_tiles, beat_cnt, tile_idx;
  logic [DLY_W-1:0] dly, dly_cnt;
  logic [DW-1:0]    drain_cnt;
  logic [1:0]       inst_q;
  logic [RD_LAT-1:0] rd_q;
  logic [COL-1:0]   shift_q;
  logic             done_q;

  logic issue, accept, done_set, last_tile, tile_end;
  logic beat_inc, beat_clr, dly_inc, dly_clr;
  logic drain_inc, drain_clr, tile_inc;

  // First per-tile phase: empty phases are skipped entirely.
  function automatic state_t entry(input logic k_zero,
                                   input logic d_zero);
    if (!k_zero)     return FEED;
    else if (!d_zero) return FLUSH;
    else             return DRAIN;
  endfunction

  always_comb begin
    nxt       = state;
    issue     = 1'b0;
    accept    = 1'b0;
    done_set  = 1'b0;
    tile_end  = 1'b0;
    beat_inc  = 1'b0;
    beat_clr  = 1'b0;
    dly_inc   = 1'b0;
    dly_clr   = 1'b0;
    drain_inc = 1'b0;
    drain_clr = 1'b0;
    tile_inc  = 1'b0;
    last_tile = (tile_idx == num_tiles - CNT_W'(1));
    unique case (state)
      IDLE: begin
        if (start_i) begin
          accept = 1'b1;
          if (num_tiles_i == '0)
            done_set = 1'b1;
          else
            nxt = entry(num_k_i == '0, dly_i == '0);
        end
      end
      FEED: begin
        issue = l0_rd_ready_i & ififo_rd_ready_i
              & (beat_cnt != num_k);
        if (issue) begin
          if (beat_cnt == num_k - CNT_W'(1)) begin
            beat_clr = 1'b1;
            nxt = (dly == '0) ? DRAIN : FLUSH;
          end else begin
            beat_inc = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (dly_cnt == dly - DLY_W'(1)) begin
          dly_clr = 1'b1;
          nxt = DRAIN;
        end else begin
          dly_inc = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DW'(COL - 1)) begin
          drain_clr = 1'b1;
          if (dly != '0) nxt = GAP;
          else           tile_end = 1'b1;
        end else begin
          drain_inc = 1'b1;
        end
      end
      GAP: begin
        if (dly_cnt == dly - DLY_W'(1)) begin
          dly_clr  = 1'b1;
          tile_end = 1'b1;
        end else begin
          dly_inc = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
    if (tile_end) begin
      if (last_tile) begin
        nxt      = IDLE;
        done_set = 1'b1;
      end else begin
        tile_inc = 1'b1;
        nxt = entry(num_k == '0, dly == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      num_k     <= '0;
      num_tiles <= '0;
      dly       <= '0;
      beat_cnt  <= '0;
      tile_idx  <= '0;
      dly_cnt   <= '0;
      drain_cnt <= '0;
      inst_q    <= '0;
      rd_q      <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        num_k     <= num_k_i;
        num_tiles <= num_tiles_i;
        dly       <= dly_i;
        tile_idx  <= '0;
      end else if (tile_inc) begin
        tile_idx <= tile_idx + CNT_W'(1);
      end
      if (beat_clr)      beat_cnt <= '0;
      else if (beat_inc) beat_cnt <= beat_cnt + CNT_W'(1);
      if (dly_clr)       dly_cnt <= '0;
      else if (dly_inc)  dly_cnt <= dly_cnt + DLY_W'(1);
      if (drain_clr)      drain_cnt <= '0;
      else if (drain_inc) drain_cnt <= drain_cnt + DW'(1);
      inst_q  <= issue ? 2'b01 : 2'b00;
      rd_q    <= RD_LAT'({rd_q, issue});
      shift_q <= COL'({shift_q, state == DRAIN});
      done_q  <= done_set;
    end
  end

`ifdef OS_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= '0;
    else if (accept)
      stall_q <= '0;
    else if (state == FEED && !issue && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'h0;
`endif

  assign inst_o        = inst_q;
  assign l0_rd_en_o    = rd_q[RD_LAT-1];
  assign ififo_rd_en_o = rd_q[RD_LAT-1];
  assign shift_psum_o  = shift_q;
  assign tile_idx_o    = tile_idx;
  assign busy_o        = (state != IDLE);
  assign done_o        = done_q;

endmodule

// File: tb/tb_os_array_seq_ctrl.sv
// Bench for os_array_seq_ctrl: per-job timeline model predicts every output cycle.
// A second instance covers COL=4, RD_LAT=1, CNT_W=10.
module tb_os_array_seq_ctrl;

  localparam int COL = 8;
  localparam int RDL = 2;
  localparam int LEN = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] nk, nt;
  logic [3:0] dl;
  logic       l0r, ffr;
  logic [1:0] inst;
  logic       l0en, ffen, busy, done;
  logic [7:0] shift, tile;
  logic [15:0] stall;

  logic       b_start;
  logic [9:0] b_nk, b_nt;
  logic [3:0] b_dl;
  logic       b_rdy = 1'b1;
  logic [1:0] b_inst;
  logic       b_l0en, b_ffen, b_busy, b_done;
  logic [3:0] b_shift;
  logic [9:0] b_tile;
  logic [15:0] b_stall;

  int checks = 0;
  int errors = 0;

  bit e_issue [LEN];
  bit e_drain [LEN];
  bit e_busy  [LEN];
  bit e_done  [LEN];
  bit e_stl   [LEN];
  int e_tile  [LEN];
  bit rl0     [LEN];
  bit rff     [LEN];

  always #5 clk = ~clk;

  os_array_seq_ctrl #(.COL(COL), .CNT_W(8), .DLY_W(4), .RD_LAT(RDL)) dut (
    .clk(clk), .reset(reset), .start_i(start),
    .num_k_i(nk), .num_tiles_i(nt), .dly_i(dl),
    .l0_rd_ready_i(l0r), .ififo_rd_ready_i(ffr),
    .inst_o(inst), .l0_rd_en_o(l0en), .ififo_rd_en_o(ffen),
    .shift_psum_o(shift), .tile_idx_o(tile), .busy_o(busy),
    .done_o(done), .stall_cnt_o(stall)
  );

  os_array_seq_ctrl #(.COL(4), .CNT_W(10), .DLY_W(4), .RD_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .start_i(b_start),
    .num_k_i(b_nk), .num_tiles_i(b_nt), .dly_i(b_dl),
    .l0_rd_ready_i(b_rdy), .ififo_rd_ready_i(b_rdy),
    .inst_o(b_inst), .l0_rd_en_o(b_l0en), .ififo_rd_en_o(b_ffen),
    .shift_psum_o(b_shift), .tile_idx_o(b_tile), .busy_o(b_busy),
    .done_o(b_done), .stall_cnt_o(b_stall)
  );

  task automatic chk(input string tag, input int r,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s r=%0d observed=%0h expected=%0h", tag, r, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_inst"}, 0, inst, 0);
    chk({tag, "_l0en"}, 0, l0en, 0);
    chk({tag, "_ffen"}, 0, ffen, 0);
    chk({tag, "_shift"}, 0, shift, 0);
    chk({tag, "_tile"}, 0, tile, 0);
    chk({tag, "_busy"}, 0, busy, 0);
    chk({tag, "_done"}, 0, done, 0);
    chk({tag, "_stall"}, 0, stall, 0);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // pat: 0 readies high, 1 random, 2 l0 low every 3rd cycle
  task automatic run_job(input int k, input int tiles, input int d,
                         input int pat, input int abort_beat,
                         input bit restart);
    int t, f, done_t, abort_at, restart_at, r_end, stl_acc;
    logic [7:0] sh;
    for (int u = 0; u < LEN; u++) begin
      e_issue[u] = 0; e_drain[u] = 0; e_busy[u] = 0;
      e_done[u] = 0; e_stl[u] = 0; e_tile[u] = 0;
      case (pat)
        1: begin
          rl0[u] = ($urandom_range(3) != 0);
          rff[u] = ($urandom_range(3) != 0);
        end
        2: begin rl0[u] = (u % 3 != 2); rff[u] = 1'b1; end
        default: begin rl0[u] = 1'b1; rff[u] = 1'b1; end
      endcase
    end
    abort_at = -1;
    restart_at = -1;
    t = 1;
    for (int i = 0; i < tiles; i++) begin
      f = 0;
      while (f < k && t < LEN - 64) begin
        e_busy[t] = 1; e_tile[t] = i;
        if (rl0[t] && rff[t]) begin
          e_issue[t] = 1;
          f++;
          if (f == abort_beat && abort_at < 0) abort_at = t;
        end else begin
          e_stl[t] = 1;
        end
        t++;
      end
      for (int j = 0; j < d; j++) begin
        e_busy[t] = 1; e_tile[t] = i; t++;
      end
      for (int j = 0; j < COL; j++) begin
        e_busy[t] = 1; e_tile[t] = i; e_drain[t] = 1;
        if (restart_at < 0) restart_at = t;
        t++;
      end
      for (int j = 0; j < d; j++) begin
        e_busy[t] = 1; e_tile[t] = i; t++;
      end
    end
    done_t = t;
    e_done[t] = 1;
    for (int u = t; u < LEN; u++) e_tile[u] = (tiles > 0) ? tiles - 1 : 0;
    r_end = (abort_at >= 0) ? abort_at : done_t + COL + 1;

    sh = '0;
    stl_acc = 0;
    for (int r = 0; r <= r_end; r++) begin
      start = (r == 0) || (restart && r == restart_at);
      if (r == 0) begin
        nk = 8'(k); nt = 8'(tiles); dl = 4'(d);
      end else if (restart && r == restart_at) begin
        nk = 8'd3; nt = 8'd5; dl = 4'd1;
      end else begin
        nk = 8'($urandom); nt = 8'($urandom); dl = 4'($urandom);
      end
      l0r = rl0[r];
      ffr = rff[r];
      reset = (r == abort_at);
      @(negedge clk);
      if (r >= 1) begin
        sh = {sh[6:0], e_drain[r-1]};
        stl_acc += int'(e_stl[r-1]);
        chk("inst", r, inst, {1'b0, e_issue[r-1]});
        chk("l0_rd_en", r, l0en, (r >= RDL) ? e_issue[r-RDL] : 1'b0);
        chk("ififo_rd_en", r, ffen, (r >= RDL) ? e_issue[r-RDL] : 1'b0);
        chk("shift_psum", r, shift, sh);
        chk("tile_idx", r, tile, e_tile[r]);
        chk("busy", r, busy, e_busy[r]);
        chk("done", r, done, e_done[r]);
`ifdef OS_SEQ_STALL_CNT_EN
        chk("stall_cnt", r, stall, stl_acc);
`else
        chk("stall_cnt", r, stall, 0);
`endif
      end
      @(posedge clk); #1;
    end
    if (abort_at >= 0) begin
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk_zero("abort");
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  initial begin
    int beats;
    logic [3:0] bsh;
    reset = 1'b1;
    start = 1'b0; nk = '0; nt = '0; dl = '0; l0r = 1'b0; ffr = 1'b0;
    b_start = 1'b0; b_nk = '0; b_nt = '0; b_dl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    chk("reset_b_busy", 0, b_busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    run_job(72, 2, 8, 0, 0, 1'b0);
    run_job(16, 1, 3, 2, 0, 1'b0);
    run_job(5, 0, 3, 0, 0, 1'b0);
    run_job(0, 1, 0, 0, 0, 1'b0);
    run_job(72, 2, 2, 0, 30, 1'b0);
    run_job(20, 1, 1, 1, 0, 1'b0);
    run_job(10, 2, 2, 0, 0, 1'b1);
    repeat (5) begin
      run_job($urandom_range(0, 40), $urandom_range(1, 3),
              $urandom_range(0, 5), 1, 0, 1'b0);
    end
    run_job(255, 1, 1, 0, 0, 1'b0);

    // 600 beats, dly 2: feed 1..600, drain 603..606, done at 609
    b_nk = 10'd600; b_nt = 10'd1; b_dl = 4'd2; b_start = 1'b1;
    bsh = '0;
    beats = 0;
    for (int r = 0; r <= 615; r++) begin
      if (r == 1) b_start = 1'b0;
      @(negedge clk);
      if (r >= 1) begin
        bsh = {bsh[2:0], (r - 1 >= 603 && r - 1 <= 606)};
        chk("b_inst", r, b_inst, {1'b0, (r >= 2 && r <= 601)});
        chk("b_l0_rd_en", r, b_l0en, (r >= 2 && r <= 601));
        chk("b_ififo_rd_en", r, b_ffen, (r >= 2 && r <= 601));
        chk("b_shift_psum", r, b_shift, bsh);
        chk("b_busy", r, b_busy, (r <= 608));
        chk("b_done", r, b_done, (r == 609));
        chk("b_tile_idx", r, b_tile, 0);
        chk("b_stall_cnt", r, b_stall, 0);
        if (b_inst == 2'b01) beats++;
      end
      @(posedge clk); #1;
    end
    chk("b_beats", 0, beats, 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
